// File: rtl/tt_prim_pkg.sv
// Shared types and constants for the tt_prim tristate bus driver family.
package tt_prim_pkg;

  localparam int unsigned TT_TBUF_TA_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TURN_ON  = 2'd1,
    DRIVE    = 2'd2,
    TURN_OFF = 2'd3
  } tbuf_state_e;

endpackage

// File: rtl/tt_prim_tbuf_bus_tbuf.sv
// Single-bit tristate cell. HIGH_DRIVE selects the x8 drive-strength cell at
// implementation time; behaviourally both flavours are identical.
module tt_prim_tbuf_bus_tbuf #(
  parameter int unsigned HIGH_DRIVE = 0
) (
  input  logic a,
  input  logic tx,
  inout  wire  z
);

  if (HIGH_DRIVE != 0) begin : g_x8
    assign z = tx ? a : 1'bz;
  end else begin : g_x1
    assign z = tx ? a : 1'bz;
  end

endmodule

// File: rtl/tt_prim_tbuf_bus.sv
// WIDTH-bit registered tristate bus driver with request/grant handshake and
// break-before-make turnaround cycles on both enable and release.
// Optional feature macro: TT_TBUF_READBACK_EN adds a sticky `contention`
// output that flags any bus readback mismatch while driving.
module tt_prim_tbuf_bus
  import tt_prim_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned TURNAROUND = 2,
  parameter int unsigned HIGH_DRIVE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             drv_req,
  input  logic [WIDTH-1:0] drv_data,
  input  logic             bus_busy,
  output logic             drv_gnt,
  output logic             bus_own,
`ifdef TT_TBUF_READBACK_EN
  output logic             contention,
`endif
  inout  wire  [WIDTH-1:0] bus_z
);

  localparam logic [TT_TBUF_TA_W-1:0] TA_LOAD = TT_TBUF_TA_W'(TURNAROUND);

  tbuf_state_e             state_q, state_d;
  logic [TT_TBUF_TA_W-1:0] cnt_q, cnt_d;
  logic                    en_q;
  logic [WIDTH-1:0]        data_q;

  // Next-state and turnaround counter; bus_busy only gates the IDLE exit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (drv_req && !bus_busy) begin
          state_d = TURN_ON;
          cnt_d   = TA_LOAD;
        end
      end
      TURN_ON: begin
        if (!drv_req) begin
          state_d = TURN_OFF;
          cnt_d   = TA_LOAD;
        end else if (cnt_q == '0) begin
          state_d = DRIVE;
        end else begin
          cnt_d = cnt_q - TT_TBUF_TA_W'(1);
        end
      end
      DRIVE: begin
        if (!drv_req) begin
          state_d = TURN_OFF;
          cnt_d   = TA_LOAD;
        end
      end
      TURN_OFF: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - TT_TBUF_TA_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State register plus state-decoded output flops; reset drops the bus at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drv_gnt <= 1'b0;
      bus_own <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drv_gnt <= (state_d == DRIVE);
      bus_own <= (state_d != IDLE);
      en_q    <= (state_d == DRIVE);
      data_q  <= drv_data;
    end
  end

`ifdef TT_TBUF_READBACK_EN
  logic drive_seen_q;

  // Sticky readback check, skipping the first DRIVE cycle while the bus settles.
  always_ff @(posedge clk) begin
    if (rst) begin
      drive_seen_q <= 1'b0;
      contention   <= 1'b0;
    end else begin
      drive_seen_q <= (state_q == DRIVE);
      if ((state_q == DRIVE) && drive_seen_q && (bus_z !== data_q)) begin
        contention <= 1'b1;
      end
    end
  end
`endif

  // One tristate cell per bit, all sharing the registered enable.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tt_prim_tbuf_bus_tbuf #(
      .HIGH_DRIVE(HIGH_DRIVE)
    ) u_tbuf (
      .a  (data_q[i]),
      .tx (en_q),
      .z  (bus_z[i])
    );
  end

endmodule

// File: tb/tb_tt_prim_tbuf_bus.sv
// Self-checking bench for tt_prim_tbuf_bus: directed scenarios plus random
// traffic against a phase/countdown reference model. A pull-low keeper on the
// bus is enabled whenever the model says the DUT must not drive, so a released
// bus reads 8'h00 and any stray drive shows up as nonzero data.
module tb_tt_prim_tbuf_bus;

  localparam int TA = 2;
  localparam int W  = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         drv_req;
  logic [W-1:0] drv_data;
  logic         bus_busy;
  logic         drv_gnt;
  logic         bus_own;
`ifdef TT_TBUF_READBACK_EN
  logic         contention;
`endif
  wire  [W-1:0] bus_z;

  logic         ext_en;
  logic [W-1:0] ext_val;
  assign bus_z = ext_en ? ext_val : 'z;

  tt_prim_tbuf_bus #(
    .WIDTH      (W),
    .TURNAROUND (TA),
    .HIGH_DRIVE (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .drv_req    (drv_req),
    .drv_data   (drv_data),
    .bus_busy   (bus_busy),
    .drv_gnt    (drv_gnt),
    .bus_own    (bus_own),
`ifdef TT_TBUF_READBACK_EN
    .contention (contention),
`endif
    .bus_z      (bus_z)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0=free, 1=dead before drive, 2=driving, 3=dead after.
  // m_left counts the dead cycles still to spend in the current dead phase.
  int           m_phase = 0;
  int           m_left  = 0;
  int           m_age   = 0;
  logic [W-1:0] m_data  = '0;
  bit           m_cont  = 1'b0;
  bit           force_on = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_phase = 0; m_left = 0; m_age = 0; m_data = '0; m_cont = 1'b0;
    end else begin
      if (force_on && m_phase == 2 && m_age >= 2) m_cont = 1'b1;
      m_data = drv_data;
      case (m_phase)
        0: if (drv_req && !bus_busy) begin m_phase = 1; m_left = TA + 1; end
        1: begin
          if (!drv_req) begin
            m_phase = 3; m_left = TA + 1;
          end else begin
            m_left--;
            if (m_left == 0) m_phase = 2;
          end
        end
        2: if (!drv_req) begin m_phase = 3; m_left = TA + 1; end
        default: begin
          m_left--;
          if (m_left == 0) m_phase = 0;
        end
      endcase
      m_age = (m_phase == 2) ? m_age + 1 : 0;
    end
    ext_en  = force_on ? 1'b1 : (m_phase != 2);
    ext_val = force_on ? 8'hFE : 8'h00;
  endtask

  task automatic compare_all();
    chk_eq("own", 32'(bus_own), 32'(m_phase != 0));
    chk_eq("gnt", 32'(drv_gnt), 32'(m_phase == 2));
    if (!force_on) chk_eq("bus", 32'(bus_z), 32'((m_phase == 2) ? m_data : 8'h00));
`ifdef TT_TBUF_READBACK_EN
    chk_eq("cont", 32'(contention), 32'(m_cont));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  initial begin
    int n;
    rst = 1'b1; drv_req = 1'b1; bus_busy = 1'b0; drv_data = 8'h5A;
    ext_en = 1'b1; ext_val = 8'h00;

    // Reset held with a pending request.
    step(); chk_eq("rst_own", 32'(bus_own), 0); chk_eq("rst_bus", 32'(bus_z), 0);
    step(); chk_eq("rst_gnt", 32'(drv_gnt), 0);
    rst = 1'b0; drv_req = 1'b0;
    step(); step();

    // Normal transfer; cycle 0 is the cycle drv_req is first presented.
    drv_req = 1'b1;
    step(); chk_eq("norm_own_c1", 32'(bus_own), 1);
    step(); step(); chk_eq("norm_gnt_c3", 32'(drv_gnt), 0);
    step(); chk_eq("norm_gnt_c4", 32'(drv_gnt), 1); drv_data = 8'hA5;
    step(); chk_eq("norm_bus_c5", 32'(bus_z), 32'h A5);
    step(); step(); step();
    drv_req = 1'b0;
    step(); chk_eq("norm_gnt_c9", 32'(drv_gnt), 0); chk_eq("norm_bus_c9", 32'(bus_z), 0);
    step(); step(); chk_eq("norm_own_c11", 32'(bus_own), 1);
    step(); chk_eq("norm_own_c12", 32'(bus_own), 0);

    // Blocked by another driver, then released.
    bus_busy = 1'b1; drv_req = 1'b1; drv_data = 8'h77;
    repeat (10) step();
    chk_eq("blk_own", 32'(bus_own), 0);
    bus_busy = 1'b0;
    step(); chk_eq("blk_release", 32'(bus_own), 1);

    // Abort during the leading dead time: bus never driven.
    drv_req = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(); n++;
      if (!bus_own) break;
    end
    chk_eq("abort_len", 32'(n), 32'(TA + 2));

    // Reset in the middle of driving.
    drv_req = 1'b1; drv_data = 8'h3C;
    repeat (TA + 2) step();
    step(); chk_eq("mid_bus", 32'(bus_z), 32'h3C);
    rst = 1'b1;
    step();
    chk_eq("mid_rst_own", 32'(bus_own), 0);
    chk_eq("mid_rst_gnt", 32'(drv_gnt), 0);
    chk_eq("mid_rst_bus", 32'(bus_z), 0);
    rst = 1'b0; drv_req = 1'b0;
    step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(63) == 0);
      if ($urandom_range(7) == 0) drv_req = ~drv_req;
      bus_busy = ($urandom_range(2) == 0);
      drv_data = W'($urandom);
      step();
    end

`ifdef TT_TBUF_READBACK_EN
    // Foreign driver pulls bit0 low while we drive 0xFF.
    rst = 1'b1; drv_req = 1'b0; bus_busy = 1'b0; step();
    rst = 1'b0; drv_req = 1'b1; drv_data = 8'hFF;
    repeat (TA + 2) step();
    step();
    force_on = 1'b1; ext_en = 1'b1; ext_val = 8'hFE;
    step(); chk_eq("rb_set", 32'(contention), 1);
    force_on = 1'b0; drv_req = 1'b0;
    repeat (TA + 3) step();
    chk_eq("rb_sticky", 32'(contention), 1);
    rst = 1'b1; step(); chk_eq("rb_clear", 32'(contention), 0);
    rst = 1'b0; step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
